// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider_if -- operand/result handshake bundle for seq_divider
// Revision: 1.0
// ============================================================================
interface seq_divider_if #(
  parameter int WIDTH  = 8,
  parameter int DWIDTH = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  dividend;
  logic [DWIDTH-1:0] divisor;
  logic [DWIDTH-1:0] rem_in;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  quotient;
  logic [DWIDTH-1:0] remainder;
  logic              div_err;

  modport master (
    output in_valid, dividend, divisor, rem_in, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_err
  );

  modport slave (
    input  in_valid, dividend, divisor, rem_in, out_ready,
    output in_ready, out_valid, quotient, remainder, div_err
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : seq_divider -- restoring divider, one quotient bit per clock, MSB first
// Revision: 1.0
// ============================================================================
module seq_divider #(
  parameter int WIDTH  = 8,
  parameter int DWIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [DWIDTH-1:0] dvs_q, dvs_d;
  logic [DWIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d;
  logic [DWIDTH-1:0] remainder_q, remainder_d;
  logic              div_err_q, div_err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DWIDTH:0]   t;
  logic [DWIDTH:0]   t_sub;
  logic              t_ge;
  logic [DWIDTH-1:0] r_step;
  logic              operand_bad;

  // dvd_q doubles as the quotient accumulator: dividend bits leave at the MSB
  // while quotient bits enter at the LSB, so after WIDTH steps it holds the quotient.
  assign t           = {r_q, dvd_q[WIDTH-1]};
  assign t_ge        = (t >= {1'b0, dvs_q});
  assign t_sub       = t - {1'b0, dvs_q};
  assign r_step      = t_ge ? t_sub[DWIDTH-1:0] : t[DWIDTH-1:0];
  assign operand_bad = (bus.divisor == '0) || (bus.rem_in >= bus.divisor);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    r_d         = r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_err_d   = div_err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          in_ready_d = 1'b0;
          if (operand_bad) begin
            state_d     = S_DONE;
            quotient_d  = '1;
            remainder_d = bus.rem_in;
            div_err_d   = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d   = S_RUN;
            dvd_d     = bus.dividend;
            dvs_d     = bus.divisor;
            r_d       = bus.rem_in;
            cnt_d     = CW'(WIDTH - 1);
            div_err_d = 1'b0;
          end
        end
      end

      S_RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], t_ge};
        r_d   = r_step;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          quotient_d  = {dvd_q[WIDTH-2:0], t_ge};
          remainder_d = r_step;
          out_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      r_q         <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_err_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      r_q         <= r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_err_q   <= div_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_err   = div_err_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_divider -- self-checking bench for seq_divider (WIDTH=8, DWIDTH=3)
// Revision: 1.0
// ============================================================================
module tb_seq_divider;

  localparam int W = 8;
  localparam int D = 3;

  logic clk;
  logic rst;

  seq_divider_if #(.WIDTH(W), .DWIDTH(D)) bus ();

  seq_divider #(.WIDTH(W), .DWIDTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // observations returned by run_op
  logic [W-1:0] q_o;
  logic [D-1:0] r_o;
  logic         e_o;
  int           lat_o;
  bit           to_o;
  bit           st_o;
  bit           id_o;
  time          tacc_o;

  // Golden model: plain integer division of rem_in*2^W + dividend.
  function automatic void ref_div(input int dvd, input int dvs, input int rin,
                                  output int q, output int r, output bit e);
    int n;
    if (dvs == 0 || rin >= dvs) begin
      q = (1 << W) - 1;
      r = rin;
      e = 1'b1;
    end else begin
      n = rin * (1 << W) + dvd;
      q = n / dvs;
      r = n % dvs;
      e = 1'b0;
    end
  endfunction

  // Drives one operation end to end and reports what was seen; no checks here.
  task automatic run_op(input logic [W-1:0] dvd, input logic [D-1:0] dvs,
                        input logic [D-1:0] rin, input int hold);
    int n;
    to_o = 1'b0; st_o = 1'b1; id_o = 1'b1; lat_o = 0;
    q_o = '0; r_o = '0; e_o = 1'b0; tacc_o = 0;
    @(negedge clk);
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      to_o = 1'b1;
      return;
    end
    bus.in_valid = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.rem_in   = rin;
    @(posedge clk);
    tacc_o = $time;
    #1;
    bus.in_valid = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = D'($urandom);
    bus.rem_in   = D'($urandom);
    do begin
      @(posedge clk);
      lat_o++;
      @(negedge clk);
    end while (bus.out_valid !== 1'b1 && lat_o < 50);
    if (bus.out_valid !== 1'b1) begin
      to_o = 1'b1;
      return;
    end
    q_o = bus.quotient;
    r_o = bus.remainder;
    e_o = bus.div_err;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = ($urandom_range(0, 1) == 1);
      bus.dividend = W'($urandom);
      bus.divisor  = D'($urandom);
      bus.rem_in   = D'($urandom);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== q_o ||
          bus.remainder !== r_o || bus.div_err !== e_o)
        st_o = 1'b0;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== q_o ||
        bus.remainder !== r_o || bus.div_err !== e_o)
      id_o = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.rem_in = '0;
    #1;
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b q=%0d r=%0d err=%b, want rdy=1 vld=0 q=0 r=0 err=0",
               bus.in_ready, bus.out_valid, bus.quotient, bus.remainder, bus.div_err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: rdy=%b vld=%b, want rdy=1 vld=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    run_op(8'd63, 3'd3, 3'd0, 0);
    n_vec++;
    if (to_o || q_o !== 8'd21 || r_o !== 3'd0 || e_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_63_3: to=%0d q=%0d r=%0d err=%b, want q=21 r=0 err=0", to_o, q_o, r_o, e_o);
    end
    n_vec++;
    if (lat_o != W) begin
      n_err++;
      $display("FAIL latency_legal: got %0d edges, want %0d", lat_o, W);
    end
    run_op(8'd100, 3'd7, 3'd0, 1);
    n_vec++;
    if (to_o || q_o !== 8'd14 || r_o !== 3'd2 || e_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_100_7: to=%0d q=%0d r=%0d err=%b, want q=14 r=2 err=0", to_o, q_o, r_o, e_o);
    end
    n_vec++;
    if (!id_o) begin
      n_err++;
      $display("FAIL return_idle: vld=%b rdy=%b after handshake, want vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_chain();
    // value 2*256+5 = 517: 517/3 = 172 rem 1
    run_op(8'd5, 3'd3, 3'd2, 0);
    n_vec++;
    if (to_o || q_o !== 8'd172 || r_o !== 3'd1 || e_o !== 1'b0) begin
      n_err++;
      $display("FAIL chain_517_3: to=%0d q=%0d r=%0d err=%b, want q=172 r=1 err=0", to_o, q_o, r_o, e_o);
    end
  endtask

  task automatic test_errors();
    run_op(8'd77, 3'd0, 3'd1, 0);
    n_vec++;
    if (to_o || q_o !== 8'd255 || r_o !== 3'd1 || e_o !== 1'b1) begin
      n_err++;
      $display("FAIL err_div0: to=%0d q=%0d r=%0d err=%b, want q=255 r=1 err=1", to_o, q_o, r_o, e_o);
    end
    n_vec++;
    if (lat_o != 1) begin
      n_err++;
      $display("FAIL latency_err: got %0d edges, want 1", lat_o);
    end
    run_op(8'd9, 3'd2, 3'd3, 2);
    n_vec++;
    if (to_o || q_o !== 8'd255 || r_o !== 3'd3 || e_o !== 1'b1 || lat_o != 1) begin
      n_err++;
      $display("FAIL err_rem_ge_div: to=%0d q=%0d r=%0d err=%b lat=%0d, want q=255 r=3 err=1 lat=1",
               to_o, q_o, r_o, e_o, lat_o);
    end
    run_op(8'd10, 3'd4, 3'd0, 0);
    n_vec++;
    if (to_o || q_o !== 8'd2 || r_o !== 3'd2 || e_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_cleared: to=%0d q=%0d r=%0d err=%b, want q=2 r=2 err=0", to_o, q_o, r_o, e_o);
    end
  endtask

  task automatic test_backpressure();
    run_op(8'd100, 3'd7, 3'd0, 5);
    n_vec++;
    if (to_o || !st_o) begin
      n_err++;
      $display("FAIL backpressure_stable: to=%0d stable=%0d, want to=0 stable=1", to_o, st_o);
    end
    n_vec++;
    if (!id_o || bus.quotient !== 8'd14 || bus.remainder !== 3'd2) begin
      n_err++;
      $display("FAIL backpressure_hold: idle_ok=%0d q=%0d r=%0d, want idle_ok=1 q=14 r=2",
               id_o, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_back_to_back();
    time t1;
    run_op(8'd200, 3'd5, 3'd0, 0);
    t1 = tacc_o;
    run_op(8'd201, 3'd5, 3'd0, 0);
    n_vec++;
    if (to_o || (tacc_o - t1) != (W + 2) * 10 || q_o !== 8'd40 || r_o !== 3'd1) begin
      n_err++;
      $display("FAIL back_to_back: spacing=%0t q=%0d r=%0d, want spacing=%0d q=40 r=1",
               tacc_o - t1, q_o, r_o, (W + 2) * 10);
    end
  endtask

  task automatic test_reset_mid_run();
    int bad;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.dividend = 8'd200; bus.divisor = 3'd3; bus.rem_in = 3'd0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (W - 3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== '0 ||
        bus.remainder !== '0 || bus.div_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_run: vld=%b rdy=%b q=%0d r=%0d err=%b, want vld=0 rdy=1 q=0 r=0 err=0",
               bus.out_valid, bus.in_ready, bus.quotient, bus.remainder, bus.div_err);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (W + 4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_no_partial: out_valid high %0d cycles, want 0", bad);
    end
    run_op(8'd200, 3'd3, 3'd0, 0);
    n_vec++;
    if (to_o || q_o !== 8'd66 || r_o !== 3'd2 || e_o !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset_op: to=%0d q=%0d r=%0d err=%b, want q=66 r=2 err=0", to_o, q_o, r_o, e_o);
    end
  endtask

  task automatic test_exhaustive();
    int eq, er;
    bit ee;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 1; b < (1 << D); b++) begin
        run_op(W'(a), D'(b), '0, $urandom_range(0, 1));
        ref_div(a, b, 0, eq, er, ee);
        n_vec++;
        if (to_o || !st_o || !id_o || q_o !== W'(eq) || r_o !== D'(er) || e_o !== ee || lat_o != W) begin
          n_err++;
          $display("FAIL exhaustive %0d/%0d: to=%0d st=%0d id=%0d q=%0d r=%0d err=%b lat=%0d, want q=%0d r=%0d err=%0d lat=%0d",
                   a, b, to_o, st_o, id_o, q_o, r_o, e_o, lat_o, eq, er, ee, W);
        end
      end
    end
  endtask

  task automatic test_random();
    int a, b, c, eq, er, el;
    bit ee;
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(0, (1 << W) - 1);
      b = $urandom_range(0, (1 << D) - 1);
      if (b > 0 && $urandom_range(0, 9) < 8) c = $urandom_range(0, b - 1);
      else c = $urandom_range(0, (1 << D) - 1);
      run_op(W'(a), D'(b), D'(c), $urandom_range(0, 3));
      ref_div(a, b, c, eq, er, ee);
      el = ee ? 1 : W;
      n_vec++;
      if (to_o || !st_o || !id_o || q_o !== W'(eq) || r_o !== D'(er) || e_o !== ee || lat_o != el) begin
        n_err++;
        $display("FAIL random (%0d*2^%0d+%0d)/%0d: to=%0d st=%0d id=%0d q=%0d r=%0d err=%b lat=%0d, want q=%0d r=%0d err=%0d lat=%0d",
                 c, W, a, b, to_o, st_o, id_o, q_o, r_o, e_o, lat_o, eq, er, ee, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chain();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
